// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family:
//   - fifo_mode_e : read-mode selector (STD registered read, FWFT fall-through)
//   - is_pow2     : parameter check used at elaboration
//   - ptr_width   : pointer width (address bits plus one wrap bit)
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // Pointers carry one extra MSB so that full and empty can be told apart
    // when the address bits are equal.
    function automatic int ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH = 256;
    localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage: one write port, one read port, 2**AW entries.
//   clk, rst     : clock; async reset clears only the registered read output
//   i_wr_en      : write strobe, i_wr_addr / i_wr_data
//   i_rd_en      : read enable (registered read only), i_rd_addr
//   o_rd_data    : read data; combinational when ASYNC_RD=1, else registered
//                  and held while i_rd_en is low
// -----------------------------------------------------------------------------
module fifo_ram #(
    parameter int DATA_WIDTH = 48,
    parameter int AW         = 8,
    parameter bit ASYNC_RD   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**AW];

    // Storage is never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    if (ASYNC_RD) begin : g_async_rd
        logic w_unused_async;
        assign w_unused_async = ^{rst, i_rd_en};
        assign o_rd_data      = r_mem[i_rd_addr];
    end else begin : g_sync_rd
        logic [DATA_WIDTH-1:0] r_rd_data;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data <= '0;
            end else if (i_rd_en) begin
                r_rd_data <= r_mem[i_rd_addr];
            end
        end
        assign o_rd_data = r_rd_data;
    end

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO for ADC sample words.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous flush (pointers, level, error flags)
//   wr_en, din    : push request and data (ignored while full)
//   rd_en         : pop request (ignored while empty)
//   dout          : read data (registered in STD mode, fall-through in FWFT)
//   dout_valid    : STD: one-cycle pulse per pop; FWFT: !empty
//   empty, full, almost_empty, almost_full, level : registered status
//   overflow, underflow : sticky refused-write / refused-read flags
// -----------------------------------------------------------------------------
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 256,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        dout_valid,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [ptr_width(DEPTH)-1:0] level,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two and at least 4");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("fifo_sync_param: require AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PW-1:0]         r_wr_ptr, r_rd_ptr, r_level;
    logic [PW-1:0]         w_wr_ptr_nxt, w_rd_ptr_nxt, w_level_nxt;
    logic                  r_empty, r_full, r_ae, r_af, r_ovf, r_udf;
    logic                  w_wr_acc, w_rd_acc, w_empty_nxt, w_full_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Acceptance uses the registered flags as they stand before the edge.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    // Status is computed from the next pointers so the registered flags
    // match the post-edge pointers with no extra cycle of lag.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (clr) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
        end
        // Modulo-2*DEPTH difference is exactly the occupancy 0..DEPTH.
        w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt  = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                      (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ae     <= 1'b1;
            r_af     <= (AF_LEVEL == 0);
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_empty  <= w_empty_nxt;
            r_full   <= w_full_nxt;
            r_ae     <= (w_level_nxt <= AE_L);
            r_af     <= (w_level_nxt >= AF_L);
            if (clr) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (wr_en && r_full)  r_ovf <= 1'b1;
                if (rd_en && r_empty) r_udf <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW),
        .ASYNC_RD   (MODE == fifo_pkg::FWFT)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc & ~clr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (din),
        .i_rd_en   (w_rd_acc & ~clr),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    if (MODE == fifo_pkg::FWFT) begin : g_fwft
        // Blank the fall-through data while empty so dout reads 0 after reset
        // instead of stale memory.
        assign dout       = r_empty ? '0 : w_rd_data;
        assign dout_valid = ~r_empty;
    end else begin : g_std
        logic r_dout_valid;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_rd_acc & ~clr;
            end
        end
        assign dout       = w_rd_data;
        assign dout_valid = r_dout_valid;
    end

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_ae;
    assign almost_full  = r_af;
    assign level        = r_level;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    localparam int DW    = 48;
    localparam int DEPTH = 8;
    localparam int AF    = 4;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout_s, dout_f;
    logic          dv_s, dv_f, emp_s, emp_f, ful_s, ful_f;
    logic          ae_s, ae_f, af_s, af_f, ovf_s, ovf_f, udf_s, udf_f;
    logic [3:0]    lvl_s, lvl_f;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_dv, m_ovf, m_udf;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_s), .dout_valid(dv_s), .empty(emp_s), .full(ful_s),
        .almost_empty(ae_s), .almost_full(af_s), .level(lvl_s),
        .overflow(ovf_s), .underflow(udf_s));

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_f), .dout_valid(dv_f), .empty(emp_f), .full(ful_f),
        .almost_empty(ae_f), .almost_full(af_f), .level(lvl_f),
        .overflow(ovf_f), .underflow(udf_f));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic chk_all();
        int n;
        n = q.size();
        chk("std_level", 64'(lvl_s), 64'(n));
        chk("std_empty", 64'(emp_s), 64'(n == 0));
        chk("std_full",  64'(ful_s), 64'(n == DEPTH));
        chk("std_ae",    64'(ae_s),  64'(n <= AE));
        chk("std_af",    64'(af_s),  64'(n >= AF));
        chk("std_ovf",   64'(ovf_s), 64'(m_ovf));
        chk("std_udf",   64'(udf_s), 64'(m_udf));
        chk("std_dv",    64'(dv_s),  64'(m_dv));
        chk("std_dout",  64'(dout_s), 64'(m_dout));
        chk("fwft_level", 64'(lvl_f), 64'(n));
        chk("fwft_ovf",   64'(ovf_f), 64'(m_ovf));
        chk("fwft_dv",    64'(dv_f),  64'(n != 0));
        if (n != 0) chk("fwft_dout", 64'(dout_f), 64'(q[0]));
    endtask

    // One clock: model the edge from the pre-edge inputs, then check after it.
    task automatic tick();
        bit wa, ra;
        wa = wr_en && (q.size() < DEPTH);
        ra = rd_en && (q.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dv  = 1'b0;
        end else begin
            if (wr_en && !wa) m_ovf = 1'b1;
            if (rd_en && !ra) m_udf = 1'b1;
            m_dv = ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(din);
        end
        chk_all();
    endtask

    task automatic push(input logic [DW-1:0] v);
        wr_en = 1'b1; rd_en = 1'b0; din = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_af", 64'(af_s), 64'(0));
        chk("rst_ae", 64'(ae_s), 64'(1));

        // Fill to capacity, then drain in order
        for (int i = 1; i <= DEPTH; i++) push(DW'(i));
        chk("fill_full", 64'(ful_s), 64'(1));
        chk("fill_level", 64'(lvl_s), 64'(8));
        for (int i = 1; i <= DEPTH; i++) begin
            pop();
            chk("drain_data", 64'(dout_s), 64'(i));
        end
        chk("drain_empty", 64'(emp_s), 64'(1));
        tick();
        chk("dv_pulse", 64'(dv_s), 64'(0));

        // Overflow: refused write never reaches the output
        for (int i = 0; i < DEPTH; i++) push(DW'(16 + i));
        push(DW'('hAA));
        chk("ovf_set", 64'(ovf_s), 64'(1));
        chk("ovf_level", 64'(lvl_s), 64'(8));
        for (int i = 0; i < DEPTH; i++) pop();
        pop();
        chk("udf_set", 64'(udf_s), 64'(1));
        chk("udf_dv", 64'(dv_s), 64'(0));

        // Flush flags, then stream at constant level across pointer wraps
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'('h100 + i));
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = DW'('h200 + i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("wrap_level", 64'(lvl_s), 64'(3));
        while (q.size() != 0) pop();

        // Fall-through: data visible without a read
        push(DW'('h55));
        chk("fwft_show", 64'(dout_f), 64'('h55));
        chk("fwft_valid", 64'(dv_f), 64'(1));
        pop();
        chk("fwft_empty", 64'(emp_f), 64'(1));
        chk("fwft_dv_off", 64'(dv_f), 64'(0));

        // Flush beats a simultaneous write
        for (int i = 0; i < DEPTH; i++) push(DW'('h300 + i));
        push(DW'('hEE));
        for (int i = 0; i < 3; i++) pop();
        chk("pre_clr_level", 64'(lvl_s), 64'(5));
        chk("pre_clr_ovf", 64'(ovf_s), 64'(1));
        clr = 1'b1; wr_en = 1'b1; din = DW'('h77);
        tick();
        clr = 1'b0; wr_en = 1'b0;
        chk("clr_level", 64'(lvl_s), 64'(0));
        chk("clr_empty", 64'(emp_s), 64'(1));
        chk("clr_ovf", 64'(ovf_s), 64'(0));
        tick();
        chk("clr_no_write", 64'(lvl_s), 64'(0));

        // Asynchronous reset in the middle of a write cycle
        for (int i = 0; i < 6; i++) push(DW'('h400 + i));
        pop();
        push(DW'('h406));
        chk("pre_rst_level", 64'(lvl_s), 64'(6));
        wr_en = 1'b1; din = DW'('h999);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        chk("arst_level", 64'(lvl_s), 64'(0));
        chk("arst_dout", 64'(dout_s), 64'(0));
        chk("arst_empty", 64'(emp_f), 64'(1));
        #2 rst = 1'b0; wr_en = 1'b0;
        push(DW'('h123));
        pop();
        chk("rt_data", 64'(dout_s), 64'('h123));
        chk("rt_valid", 64'(dv_s), 64'(1));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO for buffering ADC sample words (default 48-bit) between the capture path and the W5500 packetiser.
- Next generation of the team's basic FIFO. Adds power-of-two depth with full-capacity use, a standard or first-word-fall-through (FWFT) read mode, a fill level, programmable almost-full/almost-empty, sticky overflow/underflow error flags, and a synchronous flush.
- Single clock domain.

Parameters:
- DATA_WIDTH, 48, width of each stored word.
- DEPTH, 256, number of entries; must be a power of two, ≥ 4; all DEPTH entries are usable.
- FWFT, 0, read mode: 0 = standard (registered output), 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-4, almost_full asserts when level ≥ AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when level ≤ AE_LEVEL.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop).
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  dout holds a valid word.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds DEPTH words.
- almost_empty  out  1  level ≤ AE_LEVEL.
- almost_full  out  1  level ≥ AF_LEVEL.
- level  out  $clog2(DEPTH)+1  current word count, 0..DEPTH.
- overflow  out  1  sticky: a write was refused.
- underflow  out  1  sticky: a read was refused.

Behaviour:
- Addressing:
  - AW = $clog2(DEPTH).
  - wr_ptr and rd_ptr are AW+1 bits; the memory index is ptr[AW-1:0]; the MSB is the wrap bit.
  - full = MSBs differ and lower bits are equal; empty = pointers are equal.
  - Pointers wrap naturally modulo 2·DEPTH.
- Acceptance:
  - A write is accepted iff wr_en && !full.
  - A read is accepted iff rd_en && !empty.
  - Both use the flags as they stand before the edge.
- Simultaneous accepted read and write: both pointers advance and level is unchanged. When full, only the read is accepted; when empty, only the write.
- Level, empty, full, almost_empty and almost_full are registered. After each edge they reflect the post-edge pointer state; there is no extra lag cycle.
- Standard mode (FWFT=0):
  - On an accepted read, dout <= mem[rd_ptr] and dout_valid <= 1 at that same edge, giving one cycle of latency from the rd_en sample.
  - Otherwise dout holds its value and dout_valid <= 0, so dout_valid is a one-cycle pulse per pop.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] (asynchronous read) and dout_valid = !empty.
  - A word written at edge N appears on dout after edge N when the FIFO was empty.
  - rd_en acknowledges the displayed word; the next word appears after the edge.
- Error flags:
  - overflow <= 1 when wr_en && full.
  - underflow <= 1 when rd_en && empty.
  - Both hold until clr or rst. The refused operation changes no state.
- clr:
  - At the edge, pointers and level go to 0, empty=1, full=0, both error flags go to 0, and dout_valid=0.
  - clr takes priority over a simultaneous wr_en/rd_en; both are ignored that cycle.
  - Memory contents are not cleared.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers = 0, level = 0, empty = 1, full = 0.
  - almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
- Elaboration asserts: DEPTH is a power of two; AE_LEVEL < AF_LEVEL ≤ DEPTH.

Decomposition:
- Package fifo_pkg:
  - Parameter-check function is_pow2.
  - Localparam helpers for the pointer width (AW+1).
  - Enum fifo_mode_e with values STD and FWFT.
- Sub-module fifo_ram: simple dual-port memory with one write port and one read port. Parameter ASYNC_RD selects a combinational read (FWFT) or a registered read with read-enable (standard).
- Pointer, flag and level logic stays in fifo_sync_param.

Test Plan:
- DEPTH=8, FWFT=0: after rst, write 8 words 0x1..0x8 → full=1 after the 8th edge, level=8, almost_full=1 (AF_LEVEL=4); read 8 → dout 0x1..0x8, each one cycle after rd_en, dout_valid pulses, empty=1 after the 8th pop.
- Full FIFO, wr_en with 0xAA → overflow=1, level stays 8, 0xAA is never read. Empty FIFO, rd_en → underflow=1, dout_valid=0.
- Level 3, wr_en and rd_en together for 20 cycles → level stays 3 and output order is preserved across pointer wrap-around (≥2 wraps at DEPTH=8).
- FWFT=1: write 0x55 into an empty FIFO → dout=0x55 and dout_valid=1 after that edge without rd_en; rd_en → empty=1 and dout_valid=0 next cycle.
- Level 5 with overflow=1; assert clr together with wr_en → level=0, empty=1, overflow=0, and the write is ignored.
- Level 6; assert rst asynchronously mid-cycle during a write → all outputs take reset values immediately. After release, a write/read of 0x123 round-trips correctly.
